// File: rtl/gcd_binary_param.sv
// Iterative binary (Stein) GCD engine with parametrised operand width, a
// start/busy/valid handshake, result back-pressure and a saturating cycle count.
module gcd_binary_param #(
   parameter int WIDTH     = 32,
   parameter int CNT_WIDTH = 16
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 start_i,
   input  logic [WIDTH-1:0]     a_i,
   input  logic [WIDTH-1:0]     b_i,
   input  logic                 ready_i,
   output logic                 busy_o,
   output logic                 valid_o,
   output logic [WIDTH-1:0]     result_o,
   output logic                 coprime_o,
   output logic [CNT_WIDTH-1:0] cycles_o
);

   localparam int K_WIDTH = $clog2(WIDTH) + 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CHECK,
      S_STRIP,
      S_ANORM,
      S_BNORM,
      S_SUB,
      S_DONE
   } state_t;

   state_t               state_q, state_d;
   logic [WIDTH-1:0]     a_q, a_d;
   logic [WIDTH-1:0]     b_q, b_d;
   logic [K_WIDTH-1:0]   k_q, k_d;
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0]     result_q, result_d;
   logic                 coprime_q, coprime_d;
   logic [CNT_WIDTH-1:0] cycles_q, cycles_d;

   logic                 busy;
   logic                 finish;
   logic                 a_lt_b;
   logic [WIDTH-1:0]     diff;
   logic [CNT_WIDTH-1:0] cnt_inc;

   always_comb begin
      busy    = state_q inside {S_CHECK, S_STRIP, S_ANORM, S_BNORM, S_SUB};
      cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CNT_WIDTH'(1);
      a_lt_b  = a_q < b_q;
      // Both operands are odd in SUB, so the difference is even and nonzero.
      diff    = a_lt_b ? (b_q - a_q) : (a_q - b_q);
   end

   always_comb begin
      // NOTE: every _d takes its _q value first, so no path through the case
      // leaves a signal unassigned and no latch is inferred.
      state_d   = state_q;
      a_d       = a_q;
      b_d       = b_q;
      k_d       = k_q;
      cnt_d     = busy ? cnt_inc : cnt_q;
      result_d  = result_q;
      coprime_d = coprime_q;
      cycles_d  = cycles_q;
      finish    = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (start_i) begin
               a_d     = a_i;
               b_d     = b_i;
               k_d     = '0;
               cnt_d   = '0;
               state_d = S_CHECK;
            end
         end

         S_CHECK: begin
            if (a_q == '0) begin
               result_d = b_q;
               finish   = 1'b1;
            end else if (b_q == '0) begin
               result_d = a_q;
               finish   = 1'b1;
            end else begin
               state_d = S_STRIP;
            end
         end

         S_STRIP: begin
            if (!a_q[0] && !b_q[0]) begin
               a_d = a_q >> 1;
               b_d = b_q >> 1;
               k_d = k_q + K_WIDTH'(1);
            end else begin
               state_d = S_ANORM;
            end
         end

         S_ANORM: begin
            if (!a_q[0]) begin
               a_d = a_q >> 1;
            end else begin
               state_d = S_BNORM;
            end
         end

         S_BNORM: begin
            if (!b_q[0]) begin
               b_d = b_q >> 1;
            end else begin
               state_d = S_SUB;
            end
         end

         S_SUB: begin
            if (a_q == b_q) begin
               // The odd part shifted back by k never exceeds the smaller operand.
               result_d = a_q << k_q;
               finish   = 1'b1;
            end else begin
               a_d     = a_lt_b ? a_q : b_q;
               b_d     = diff;
               state_d = S_BNORM;
            end
         end

         S_DONE: begin
            if (ready_i) begin
               state_d = S_IDLE;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (finish) begin
         state_d   = S_DONE;
         coprime_d = (result_d == WIDTH'(1));
         cycles_d  = cnt_inc;
      end
   end

   always_ff @(posedge clk_i) begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values
      // regardless of statement order.
      if (rst_i) begin
         state_q   <= S_IDLE;
         a_q       <= '0;
         b_q       <= '0;
         k_q       <= '0;
         cnt_q     <= '0;
         result_q  <= '0;
         coprime_q <= 1'b0;
         cycles_q  <= '0;
      end else begin
         state_q   <= state_d;
         a_q       <= a_d;
         b_q       <= b_d;
         k_q       <= k_d;
         cnt_q     <= cnt_d;
         result_q  <= result_d;
         coprime_q <= coprime_d;
         cycles_q  <= cycles_d;
      end
   end

   assign busy_o    = busy;
   assign valid_o   = (state_q == S_DONE);
   assign result_o  = result_q;
   assign coprime_o = coprime_q;
   assign cycles_o  = cycles_q;

endmodule

// File: tb/tb_gcd_binary_param.sv
// Self-checking bench for gcd_binary_param: directed vectors, handshake corner
// cases, three parameterisations and random operands against a Euclid model.
module tb_gcd_binary_param;

   localparam int LIMIT = 1000;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] a_drv, b_drv;
   logic        start_drv, ready_drv;
   int          sel;
   bit          armed = 1'b0;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   // 32-bit instance
   logic        busy32, valid32, cop32;
   logic [31:0] res32;
   logic [15:0] cyc32;
   // 8-bit instance
   logic        busy8, valid8, cop8;
   logic [7:0]  res8;
   logic [15:0] cyc8;
   // 32-bit instance with a 2-bit counter
   logic        busys, valids, cops;
   logic [31:0] ress;
   logic [1:0]  cycs;

   gcd_binary_param #(.WIDTH(32), .CNT_WIDTH(16)) dut32 (
      .clk_i(clk), .rst_i(rst), .start_i(start_drv && sel == 0),
      .a_i(a_drv), .b_i(b_drv), .ready_i(ready_drv),
      .busy_o(busy32), .valid_o(valid32), .result_o(res32),
      .coprime_o(cop32), .cycles_o(cyc32)
   );

   gcd_binary_param #(.WIDTH(8), .CNT_WIDTH(16)) dut8 (
      .clk_i(clk), .rst_i(rst), .start_i(start_drv && sel == 1),
      .a_i(a_drv[7:0]), .b_i(b_drv[7:0]), .ready_i(ready_drv),
      .busy_o(busy8), .valid_o(valid8), .result_o(res8),
      .coprime_o(cop8), .cycles_o(cyc8)
   );

   gcd_binary_param #(.WIDTH(32), .CNT_WIDTH(2)) dut_sat (
      .clk_i(clk), .rst_i(rst), .start_i(start_drv && sel == 2),
      .a_i(a_drv), .b_i(b_drv), .ready_i(ready_drv),
      .busy_o(busys), .valid_o(valids), .result_o(ress),
      .coprime_o(cops), .cycles_o(cycs)
   );

   logic        obs_busy, obs_valid, obs_cop;
   logic [31:0] obs_result;
   logic [15:0] obs_cycles;

   always_comb begin
      obs_busy   = busy32;
      obs_valid  = valid32;
      obs_cop    = cop32;
      obs_result = res32;
      obs_cycles = cyc32;
      case (sel)
         1: begin
            obs_busy   = busy8;
            obs_valid  = valid8;
            obs_cop    = cop8;
            obs_result = {24'd0, res8};
            obs_cycles = cyc8;
         end
         2: begin
            obs_busy   = busys;
            obs_valid  = valids;
            obs_cop    = cops;
            obs_result = ress;
            obs_cycles = {14'd0, cycs};
         end
         default: ;
      endcase
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] gcd_ref(input logic [31:0] x, input logic [31:0] y);
      logic [31:0] t;
      while (y != 0) begin
         t = x % y;
         x = y;
         y = t;
      end
      return x;
   endfunction

   // Busy and valid must never overlap on any instance.
   always @(negedge clk) begin
      if (armed && !rst)
         check("busy_valid_exclusive",
               {31'd0, (busy32 & valid32) | (busy8 & valid8) | (busys & valids)}, 32'd0);
   end

   task automatic run_op(input int s, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output logic cop, output logic [15:0] cyc,
                         output int lat, output int busy_n);
      @(negedge clk);
      sel       = s;
      a_drv     = a;
      b_drv     = b;
      start_drv = 1'b1;
      @(negedge clk);
      start_drv = 1'b0;
      lat       = 0;
      busy_n    = 0;
      while (!obs_valid && lat < LIMIT) begin
         if (obs_busy) busy_n++;
         @(negedge clk);
         lat++;
      end
      check("valid_reached", {31'd0, obs_valid}, 32'd1);
      res = obs_result;
      cop = obs_cop;
      cyc = obs_cycles;
   endtask

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      logic        cop;
      int          cyc;   // -1: not checked
   } vec_t;

   vec_t        vecs[14];
   logic [31:0] r;
   logic        c;
   logic [15:0] cy;
   int          lat, busy_n;
   bit          seen_valid;
   logic [31:0] ra, rb, exp_r;
   int          sh;

   initial begin
      vecs[0]  = '{32'd48,         32'd18,         32'd6,          1'b0, 12};
      vecs[1]  = '{32'd0,          32'd7,          32'd7,          1'b0, 1};
      vecs[2]  = '{32'd0,          32'd0,          32'd0,          1'b0, 1};
      vecs[3]  = '{32'd0,          32'd1,          32'd1,          1'b1, 1};
      vecs[4]  = '{32'd1,          32'd0,          32'd1,          1'b1, 1};
      vecs[5]  = '{32'd17,         32'd5,          32'd1,          1'b1, 15};
      vecs[6]  = '{32'd7,          32'd7,          32'd7,          1'b0, 5};
      vecs[7]  = '{32'd12,         32'd8,          32'd4,          1'b0, -1};
      vecs[8]  = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b0, -1};
      vecs[9]  = '{32'hFFFF_FFFF,  32'hFFFF_FFFE,  32'd1,          1'b1, -1};
      vecs[10] = '{32'h8000_0000,  32'h4000_0000,  32'h4000_0000,  1'b0, -1};
      vecs[11] = '{32'd1024,       32'd768,        32'd256,        1'b0, -1};
      vecs[12] = '{32'd1071,       32'd462,        32'd21,         1'b0, -1};
      vecs[13] = '{32'd65536,      32'd98304,      32'd32768,      1'b0, -1};

      rst       = 1'b1;
      start_drv = 1'b0;
      ready_drv = 1'b1;
      a_drv     = '0;
      b_drv     = '0;
      sel       = 0;
      repeat (3) @(negedge clk);
      check("reset_valid",   {31'd0, valid32}, 32'd0);
      check("reset_busy",    {31'd0, busy32},  32'd0);
      check("reset_result",  res32,            32'd0);
      check("reset_coprime", {31'd0, cop32},   32'd0);
      check("reset_cycles",  {16'd0, cyc32},   32'd0);
      check("reset_result8", {24'd0, res8},    32'd0);
      rst   = 1'b0;
      armed = 1'b1;

      // Directed table on the 32-bit instance
      for (int i = 0; i < 14; i++) begin
         run_op(0, vecs[i].a, vecs[i].b, r, c, cy, lat, busy_n);
         check("vec_result",  r, vecs[i].res);
         check("vec_coprime", {31'd0, c}, {31'd0, vecs[i].cop});
         check("vec_cycles_vs_busy", {16'd0, cy}, busy_n);
         if (vecs[i].cyc >= 0) check("vec_cycles", {16'd0, cy}, vecs[i].cyc);
         if (vecs[i].a == 0 || vecs[i].b == 0) check("min_latency", lat, 32'd1);
         @(negedge clk);
         check("single_valid_cycle", {31'd0, obs_valid}, 32'd0);
      end

      // Back-pressure: hold DONE for five cycles while start is pulsed
      ready_drv = 1'b0;
      run_op(0, 32'd17, 32'd5, r, c, cy, lat, busy_n);
      for (int i = 0; i < 5; i++) begin
         check("bp_valid",  {31'd0, obs_valid}, 32'd1);
         check("bp_result", obs_result, 32'd1);
         check("bp_busy",   {31'd0, obs_busy}, 32'd0);
         a_drv     = 32'd100;
         b_drv     = 32'd10;
         start_drv = 1'b1;
         if (i == 4) ready_drv = 1'b1;
         @(negedge clk);
      end
      check("bp_idle_valid", {31'd0, obs_valid}, 32'd0);
      check("bp_idle_busy",  {31'd0, obs_busy},  32'd0);
      check("bp_idle_hold",  obs_result, 32'd1);
      start_drv = 1'b0;
      @(negedge clk);
      check("bp_start_dropped", {31'd0, obs_busy}, 32'd0);

      // Reset in the middle of an operation
      sel       = 0;
      a_drv     = 32'd1024;
      b_drv     = 32'd768;
      start_drv = 1'b1;
      @(negedge clk);
      start_drv = 1'b0;
      @(negedge clk);
      check("midreset_busy_before", {31'd0, obs_busy}, 32'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("midreset_busy",    {31'd0, obs_busy},  32'd0);
      check("midreset_valid",   {31'd0, obs_valid}, 32'd0);
      check("midreset_result",  obs_result,         32'd0);
      check("midreset_coprime", {31'd0, obs_cop},   32'd0);
      check("midreset_cycles",  {16'd0, obs_cycles}, 32'd0);
      seen_valid = 1'b0;
      for (int i = 0; i < 40; i++) begin
         seen_valid |= obs_valid;
         @(negedge clk);
      end
      check("midreset_no_valid", {31'd0, seen_valid}, 32'd0);
      run_op(0, 32'd12, 32'd8, r, c, cy, lat, busy_n);
      check("after_reset_result", r, 32'd4);

      // 8-bit instance
      run_op(1, 32'hFF, 32'hFE, r, c, cy, lat, busy_n);
      check("w8_ff_fe_result",  r, 32'd1);
      check("w8_ff_fe_coprime", {31'd0, c}, 32'd1);
      run_op(1, 32'h80, 32'h40, r, c, cy, lat, busy_n);
      check("w8_80_40_result",  r, 32'h40);
      run_op(1, 32'hFF, 32'hFF, r, c, cy, lat, busy_n);
      check("w8_ff_ff_result",  r, 32'hFF);
      for (int i = 0; i < 12; i++) begin
         ra = $urandom_range(0, 255);
         rb = $urandom_range(0, 255);
         run_op(1, ra, rb, r, c, cy, lat, busy_n);
         exp_r = gcd_ref(ra, rb);
         check("w8_rand_result",  r, exp_r);
         check("w8_rand_coprime", {31'd0, c}, {31'd0, exp_r == 32'd1});
      end

      // Saturating counter
      run_op(2, 32'h8000_0000, 32'd1, r, c, cy, lat, busy_n);
      check("sat_result",    r, 32'd1);
      check("sat_cycles",    {16'd0, cy}, 32'd3);
      check("sat_long_busy", {31'd0, busy_n > 3}, 32'd1);

      // Random operands on the 32-bit instance
      for (int i = 0; i < 48; i++) begin
         ra = $urandom;
         rb = $urandom;
         sh = $urandom_range(0, 12);
         case (i % 8)
            1: ra = ra >> $urandom_range(0, 31);
            2: begin ra = (ra >> 16) << sh; rb = (rb >> 16) << sh; end
            3: rb = ra;
            4: begin ra = ra >> 20; rb = rb >> 22; end
            5: begin ra = (ra >> 8) * 3; rb = (rb >> 8) * 3; end
            7: ra = 32'd0;
            default: ;
         endcase
         run_op(0, ra, rb, r, c, cy, lat, busy_n);
         exp_r = gcd_ref(ra, rb);
         check("rand_result",  r, exp_r);
         check("rand_coprime", {31'd0, c}, {31'd0, exp_r == 32'd1});
         check("rand_cycles_vs_busy", {16'd0, cy}, busy_n);
      end

      armed = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
